// File: rtl/craps_pkg.sv
// Shared definitions for the craps game controller.
//   craps_state_t : controller state encoding
//   SUM_MIN/MAX   : legal dice-total range
//   SEVEN         : the come-out natural / point-phase losing total
//   sum_legal()   : range check applied to every roll request
package craps_pkg;

    typedef enum logic [2:0] {
        COME_OUT   = 3'd0,
        CLS1       = 3'd1,
        EVAL1      = 3'd2,
        POINT_WAIT = 3'd3,
        CLS2       = 3'd4,
        EVAL2      = 3'd5,
        WON        = 3'd6,
        LOST       = 3'd7
    } craps_state_t;

    localparam logic [3:0] SUM_MIN = 4'd2;
    localparam logic [3:0] SUM_MAX = 4'd12;
    localparam logic [3:0] SEVEN   = 4'd7;

    function automatic logic sum_legal(input logic [3:0] s);
        return (s >= SUM_MIN) && (s <= SUM_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the win and loss tallies.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset, clears the count
//   inc     : one-cycle increment request
//   count   : current tally, sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/craps_game_ctrl.sv
// Craps game sequencer. Accepts dice totals, drives an external roll
// classifier for one cycle per roll, and tracks point, result and tallies.
// Ports:
//   clock, reset_n        : clock and asynchronous active-low reset
//   new_game              : abandon current game, back to come-out
//   roll_req, sum         : roll request and its dice total
//   cls_en, cls_num       : classifier enable and the latched total
//   d7, d711, d2312       : classifier flags, valid the cycle after cls_en
//   point, point_valid    : established point (0 when none)
//   win, lose             : game result, held until new_game
//   illegal               : one-cycle pulse for an out-of-range total
//   busy                  : low only while waiting for a roll
//   win_cnt, loss_cnt     : saturating tallies
module craps_game_ctrl
    import craps_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             new_game,
    input  logic             roll_req,
    input  logic [3:0]       sum,
    output logic             cls_en,
    output logic [3:0]       cls_num,
    input  logic             d7,
    input  logic             d711,
    input  logic             d2312,
    output logic [3:0]       point,
    output logic             point_valid,
    output logic             win,
    output logic             lose,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    craps_state_t state_reg, state_next;

    logic [3:0] cls_num_reg;
    logic [3:0] point_reg;
    logic       point_valid_reg;
    logic       win_reg;
    logic       lose_reg;
    logic       illegal_reg;

    // Strobes produced alongside the next-state decision
    logic       latch_sum;
    logic       load_point;
    logic       go_win;
    logic       go_lose;
    logic       illegal_next;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= COME_OUT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. new_game wins over everything, including a
    // roll_req in the same cycle, which is simply dropped.
    always_comb begin
        state_next   = state_reg;
        latch_sum    = 1'b0;
        load_point   = 1'b0;
        go_win       = 1'b0;
        go_lose      = 1'b0;
        illegal_next = 1'b0;
        if (new_game) begin
            state_next = COME_OUT;
        end else begin
            case (state_reg)
                COME_OUT, POINT_WAIT: begin
                    if (roll_req) begin
                        if (sum_legal(sum)) begin
                            latch_sum  = 1'b1;
                            state_next = (state_reg == COME_OUT) ? CLS1 : CLS2;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                CLS1: state_next = EVAL1;
                CLS2: state_next = EVAL2;
                EVAL1: begin
                    if (d711) begin
                        go_win     = 1'b1;
                        state_next = WON;
                    end else if (d2312) begin
                        go_lose    = 1'b1;
                        state_next = LOST;
                    end else begin
                        load_point = 1'b1;
                        state_next = POINT_WAIT;
                    end
                end
                EVAL2: begin
                    // Making the point is checked first, so a point can
                    // never be lost on its own number.
                    if (cls_num_reg == point_reg) begin
                        go_win     = 1'b1;
                        state_next = WON;
                    end else if (d7) begin
                        go_lose    = 1'b1;
                        state_next = LOST;
                    end else begin
                        state_next = POINT_WAIT;
                    end
                end
                WON, LOST: state_next = state_reg;
                default:   state_next = COME_OUT;
            endcase
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        cls_en = 1'b0;
        busy   = 1'b1;
        case (state_reg)
            COME_OUT, POINT_WAIT: busy   = 1'b0;
            CLS1, CLS2:           cls_en = 1'b1;
            default:              cls_en = 1'b0;
        endcase
    end

    // Game datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cls_num_reg     <= '0;
            point_reg       <= '0;
            point_valid_reg <= 1'b0;
            win_reg         <= 1'b0;
            lose_reg        <= 1'b0;
            illegal_reg     <= 1'b0;
        end else begin
            illegal_reg <= illegal_next;
            if (new_game) begin
                cls_num_reg     <= '0;
                point_reg       <= '0;
                point_valid_reg <= 1'b0;
                win_reg         <= 1'b0;
                lose_reg        <= 1'b0;
            end else begin
                if (latch_sum) begin
                    cls_num_reg <= sum;
                end
                if (load_point) begin
                    point_reg       <= cls_num_reg;
                    point_valid_reg <= 1'b1;
                end
                if (go_win) begin
                    win_reg <= 1'b1;
                end
                if (go_lose) begin
                    lose_reg <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_win_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (go_win),
        .count   (win_cnt)
    );

    sat_counter #(.W(CNT_W)) u_loss_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (go_lose),
        .count   (loss_cnt)
    );

    assign cls_num     = cls_num_reg;
    assign point       = point_reg;
    assign point_valid = point_valid_reg;
    assign win         = win_reg;
    assign lose        = lose_reg;
    assign illegal     = illegal_reg;

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Testbench for craps_game_ctrl: directed table, hand-written corner
// sequences, and randomized rolls checked against a rule-level game model.
module tb_craps_game_ctrl;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             new_game;
    logic             roll_req;
    logic [3:0]       sum;
    logic             cls_en;
    logic [3:0]       cls_num;
    logic             d7 = 1'b0;
    logic             d711 = 1'b0;
    logic             d2312 = 1'b0;
    logic [3:0]       point;
    logic             point_valid;
    logic             win;
    logic             lose;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int tests    = 0;
    int failures = 0;

    craps_game_ctrl #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .new_game    (new_game),
        .roll_req    (roll_req),
        .sum         (sum),
        .cls_en      (cls_en),
        .cls_num     (cls_num),
        .d7          (d7),
        .d711        (d711),
        .d2312       (d2312),
        .point       (point),
        .point_valid (point_valid),
        .win         (win),
        .lose        (lose),
        .illegal     (illegal),
        .busy        (busy),
        .win_cnt     (win_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 clock = ~clock;

    // External classifier: flags follow the classified total one cycle
    // after cls_en.
    always @(posedge clock) begin
        if (cls_en) begin
            d7    <= (cls_num == 4'd7);
            d711  <= (cls_num == 4'd7) || (cls_num == 4'd11);
            d2312 <= (cls_num == 4'd2) || (cls_num == 4'd3) || (cls_num == 4'd12);
        end
    end

    typedef struct {
        bit         ng;    // pulse new_game before the roll
        logic [3:0] s;     // dice total
        bit         acc;   // roll expected to be accepted
        bit         ill;   // illegal pulse expected
        bit         w;
        bit         l;
        logic [3:0] pt;
        bit         pv;
        int         wc;
        int         lc;
    } vec_t;

    function automatic vec_t mk(bit ng, logic [3:0] s, bit acc, bit ill, bit w, bit l,
                                logic [3:0] pt, bit pv, int wc, int lc);
        vec_t v;
        v.ng = ng; v.s = s; v.acc = acc; v.ill = ill; v.w = w; v.l = l;
        v.pt = pt; v.pv = pv; v.wc = wc; v.lc = lc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_new_game(input int wc, input int lc);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("ng_point", 32'(point), 0);
        check("ng_pv", 32'(point_valid), 0);
        check("ng_win", 32'(win), 0);
        check("ng_lose", 32'(lose), 0);
        check("ng_busy", 32'(busy), 0);
        check("ng_wcnt", 32'(win_cnt), 32'(wc));
        check("ng_lcnt", 32'(loss_cnt), 32'(lc));
    endtask

    task automatic run_roll(input vec_t v);
        sum      = v.s;
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        sum      = 4'($urandom);
        if (v.acc) begin
            check("cls_en_on", 32'(cls_en), 1);
            check("cls_num", 32'(cls_num), 32'(v.s));
            check("busy_e1", 32'(busy), 1);
            check("illegal_acc", 32'(illegal), 0);
            tick();
            check("cls_en_off", 32'(cls_en), 0);
            check("busy_e2", 32'(busy), 1);
            tick();
        end else begin
            check("illegal_pulse", 32'(illegal), 32'(v.ill));
            check("cls_en_idle", 32'(cls_en), 0);
            tick();
            check("illegal_clear", 32'(illegal), 0);
        end
        check("win", 32'(win), 32'(v.w));
        check("lose", 32'(lose), 32'(v.l));
        check("point", 32'(point), 32'(v.pt));
        check("point_valid", 32'(point_valid), 32'(v.pv));
        check("win_cnt", 32'(win_cnt), 32'(v.wc));
        check("loss_cnt", 32'(loss_cnt), 32'(v.lc));
        check("busy_final", 32'(busy), 32'(v.w | v.l));
        $display("[TB] roll sum=%0d acc=%0b ill=%0b -> win=%0b lose=%0b point=%0d pv=%0b wc=%0d lc=%0d",
                 v.s, v.acc, v.ill, win, lose, point, point_valid, win_cnt, loss_cnt);
    endtask

    // Rule-level game model
    int m_point, m_res, m_w, m_l;

    function automatic vec_t model_roll(input int s);
        vec_t v;
        v = mk(0, 4'(s), 0, 0, 0, 0, 0, 0, 0, 0);
        if (m_res == 0) begin
            if (s < 2 || s > 12) begin
                v.ill = 1;
            end else begin
                v.acc = 1;
                if (m_point == 0) begin
                    if (s == 7 || s == 11) m_res = 1;
                    else if (s == 2 || s == 3 || s == 12) m_res = 2;
                    else m_point = s;
                end else begin
                    if (s == m_point) m_res = 1;
                    else if (s == 7) m_res = 2;
                end
                if (m_res == 1 && m_w < MAXC) m_w++;
                if (m_res == 2 && m_l < MAXC) m_l++;
            end
        end
        v.w  = (m_res == 1);
        v.l  = (m_res == 2);
        v.pt = 4'(m_point);
        v.pv = (m_point != 0);
        v.wc = m_w;
        v.lc = m_l;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(0, 7,  1, 0, 1, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 3,  1, 0, 0, 1, 0, 0, 1, 1);
        tbl[2]  = mk(1, 12, 1, 0, 0, 1, 0, 0, 1, 2);
        tbl[3]  = mk(1, 6,  1, 0, 0, 0, 6, 1, 1, 2);
        tbl[4]  = mk(0, 8,  1, 0, 0, 0, 6, 1, 1, 2);
        tbl[5]  = mk(0, 6,  1, 0, 1, 0, 6, 1, 2, 2);
        tbl[6]  = mk(0, 9,  0, 0, 1, 0, 6, 1, 2, 2);
        tbl[7]  = mk(1, 4,  1, 0, 0, 0, 4, 1, 2, 2);
        tbl[8]  = mk(0, 7,  1, 0, 0, 1, 4, 1, 2, 3);
        tbl[9]  = mk(0, 5,  0, 0, 0, 1, 4, 1, 2, 3);
        tbl[10] = mk(1, 13, 0, 1, 0, 0, 0, 0, 2, 3);
        tbl[11] = mk(0, 0,  0, 1, 0, 0, 0, 0, 2, 3);
        tbl[12] = mk(0, 11, 1, 0, 1, 0, 0, 0, 3, 3);
        tbl[13] = mk(1, 9,  1, 0, 0, 0, 9, 1, 3, 3);
        tbl[14] = mk(0, 15, 0, 1, 0, 0, 9, 1, 3, 3);
        tbl[15] = mk(0, 9,  1, 0, 1, 0, 9, 1, 3, 3);
        tbl[16] = mk(1, 2,  1, 0, 0, 1, 0, 0, 3, 3);

        reset_n  = 1'b0;
        new_game = 1'b0;
        roll_req = 1'b0;
        sum      = 4'd0;
        #3;
        check("rst_state_busy", 32'(busy), 0);
        check("rst_cls_en", 32'(cls_en), 0);
        check("rst_cls_num", 32'(cls_num), 0);
        check("rst_point", 32'(point), 0);
        check("rst_pv", 32'(point_valid), 0);
        check("rst_win", 32'(win), 0);
        check("rst_lose", 32'(lose), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_wcnt", 32'(win_cnt), 0);
        check("rst_lcnt", 32'(loss_cnt), 0);
        repeat (2) tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].ng) pulse_new_game(tbl[i - 1].wc, tbl[i - 1].lc);
            run_roll(tbl[i]);
        end

        // new_game and roll_req together from a point: roll dropped
        pulse_new_game(3, 3);
        run_roll(mk(0, 5, 1, 0, 0, 0, 5, 1, 3, 3));
        new_game = 1'b1;
        roll_req = 1'b1;
        sum      = 4'd7;
        tick();
        new_game = 1'b0;
        roll_req = 1'b0;
        check("simul_busy", 32'(busy), 0);
        check("simul_cls_en", 32'(cls_en), 0);
        check("simul_point", 32'(point), 0);
        check("simul_pv", 32'(point_valid), 0);
        repeat (2) tick();
        check("simul_busy_later", 32'(busy), 0);
        check("simul_win", 32'(win), 0);
        check("simul_lose", 32'(lose), 0);
        $display("[TB] simultaneous new_game+roll: busy=%0b point=%0d", busy, point);

        // Reset asserted while the classifier is enabled for a point roll
        run_roll(mk(0, 10, 1, 0, 0, 0, 10, 1, 3, 3));
        sum      = 4'd10;
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        check("cls2_cls_en", 32'(cls_en), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_cls_en", 32'(cls_en), 0);
        check("midrst_cls_num", 32'(cls_num), 0);
        check("midrst_point", 32'(point), 0);
        check("midrst_pv", 32'(point_valid), 0);
        check("midrst_win", 32'(win), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_wcnt", 32'(win_cnt), 0);
        check("midrst_lcnt", 32'(loss_cnt), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        check("postrst_win", 32'(win), 0);
        check("postrst_busy", 32'(busy), 0);
        check("postrst_wcnt", 32'(win_cnt), 0);
        check("postrst_lcnt", 32'(loss_cnt), 0);
        $display("[TB] reset during point roll: busy=%0b wc=%0d lc=%0d", busy, win_cnt, loss_cnt);

        // Randomized games against the rule model
        m_point = 0; m_res = 0; m_w = 0; m_l = 0;
        for (int n = 0; n < 150; n++) begin
            int s;
            if ($urandom_range(0, 9) == 0) begin
                m_point = 0;
                m_res   = 0;
                pulse_new_game(m_w, m_l);
            end else begin
                if ($urandom_range(0, 7) == 0) s = int'($urandom_range(0, 15));
                else s = int'($urandom_range(2, 12));
                run_roll(model_roll(s));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
